// File: rtl/index_queue.sv
// index_queue
//
// Purpose
//   A D-slot (D = 2^IDX_WIDTH) indexed queue kept as a doubly linked list.
//   Each slot holds a payload, a valid bit and next/prev links; head, tail
//   and an (IDX_WIDTH+1)-bit count describe the queue. Commands can append,
//   pop, read, overwrite, move a slot to the tail or remove a slot from any
//   position. Any protocol error freezes the block in CRASH until reset.
//
// Handshake
//   A request is accepted on a rising edge where enable=1 and ready=1.
//   command/idx_in/data_in are captured on that same edge. ready then drops
//   for exactly two cycles and rises together with the results. idx_out,
//   data_out, empty and full are valid whenever ready=1 and hold their values
//   between operations. enable while ready=0 is ignored.
//
// Ports
//   clock     sole clock, rising edge
//   reset     asynchronous, active-high
//   command   operation code: 0 NOP, 1 ENQUEUE, 2 DEQUEUE, 3 READ, 4 WRITE,
//             5 BUMP, 6 DELETE; 7-15 illegal
//   enable    request strobe
//   idx_in    target slot for index-addressed commands
//   data_in   payload for ENQUEUE/WRITE
//   ready     idle, results valid, a request may be issued
//   crashed   sticky protocol-error flag
//   idx_out   slot result
//   data_out  payload result
//   empty     no occupied slots (registered)
//   full      all D slots occupied (registered)
//   state_dbg current FSM state (0 IDLE, 1 EXEC, 2 CRASH)

module index_queue #(
  parameter int IDX_WIDTH  = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            command,
  input  logic                  enable,
  input  logic [IDX_WIDTH-1:0]  idx_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready,
  output logic                  crashed,
  output logic [IDX_WIDTH-1:0]  idx_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic [1:0]            state_dbg
);

  localparam int D = 1 << IDX_WIDTH;
  localparam logic [IDX_WIDTH:0] D_CNT = (IDX_WIDTH+1)'(D);

  localparam logic [3:0] CMD_NOP    = 4'd0;
  localparam logic [3:0] CMD_ENQ    = 4'd1;
  localparam logic [3:0] CMD_DEQ    = 4'd2;
  localparam logic [3:0] CMD_READ   = 4'd3;
  localparam logic [3:0] CMD_WRITE  = 4'd4;
  localparam logic [3:0] CMD_BUMP   = 4'd5;
  localparam logic [3:0] CMD_DELETE = 4'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_CRASH = 2'd2
  } state_t;

  state_t state, next_state;
  // EXEC lasts two cycles; phase marks the second one, where the command commits.
  logic phase;

  logic [3:0]            cmd_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [DATA_WIDTH-1:0] slot_data [D];
  logic [IDX_WIDTH-1:0]  slot_next [D];
  logic [IDX_WIDTH-1:0]  slot_prev [D];
  logic [D-1:0]          slot_valid;
  logic [IDX_WIDTH-1:0]  head, tail;
  logic [IDX_WIDTH:0]    count, count_next;

  logic [IDX_WIDTH-1:0]  free_idx;
  logic                  op_err;
  logic                  commit;
  logic [IDX_WIDTH-1:0]  sel_prev, sel_next;

  assign sel_prev = slot_prev[idx_q];
  assign sel_next = slot_next[idx_q];

  // Lowest-numbered free slot: scan downwards so the last hit is the lowest.
  always_comb begin
    free_idx = '0;
    for (int i = D - 1; i >= 0; i--) begin
      if (!slot_valid[i]) free_idx = IDX_WIDTH'(i);
    end
  end

  always_comb begin
    op_err = 1'b0;
    case (cmd_q)
      CMD_NOP:    op_err = 1'b0;
      CMD_ENQ:    op_err = (count == D_CNT);
      CMD_DEQ:    op_err = (count == '0);
      CMD_READ,
      CMD_WRITE,
      CMD_BUMP,
      CMD_DELETE: op_err = !slot_valid[idx_q];
      default:    op_err = 1'b1;
    endcase
  end

  assign commit = (state == S_EXEC) && phase && !op_err;

  always_comb begin
    count_next = count;
    if (commit) begin
      case (cmd_q)
        CMD_ENQ:             count_next = count + (IDX_WIDTH+1)'(1);
        CMD_DEQ, CMD_DELETE: count_next = count - (IDX_WIDTH+1)'(1);
        default:             count_next = count;
      endcase
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      phase <= 1'b0;
    end else begin
      state <= next_state;
      phase <= (state == S_EXEC) && !phase;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (enable) next_state = S_EXEC;
      S_EXEC:  if (phase) next_state = op_err ? S_CRASH : S_IDLE;
      S_CRASH: next_state = S_CRASH;
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready     = (state == S_IDLE);
    crashed   = (state == S_CRASH);
    state_dbg = state;
  end

  // Request capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_q  <= CMD_NOP;
      idx_q  <= '0;
      data_q <= '0;
    end else if (state == S_IDLE && enable) begin
      cmd_q  <= command;
      idx_q  <= idx_in;
      data_q <= data_in;
    end
  end

  // Queue bookkeeping and result registers. Only a committing command
  // changes anything, so an error or a reset leaves no partial update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      idx_out    <= '0;
      data_out   <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
    end else if (commit) begin
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == D_CNT);
      case (cmd_q)
        CMD_ENQ: begin
          slot_valid[free_idx] <= 1'b1;
          if (count == '0) head <= free_idx;
          tail    <= free_idx;
          idx_out <= free_idx;
        end
        CMD_DEQ: begin
          slot_valid[head] <= 1'b0;
          head     <= slot_next[head];
          idx_out  <= head;
          data_out <= slot_data[head];
        end
        CMD_READ: begin
          idx_out  <= idx_q;
          data_out <= slot_data[idx_q];
        end
        CMD_BUMP: begin
          if (idx_q != tail) begin
            if (idx_q == head) head <= sel_next;
            tail <= idx_q;
          end
        end
        CMD_DELETE: begin
          slot_valid[idx_q] <= 1'b0;
          if (idx_q == head) head <= sel_next;
          if (idx_q == tail) tail <= sel_prev;
        end
        default: ;
      endcase
    end
  end

  // Payload and link storage: no reset needed, a slot's contents are only
  // meaningful while its valid bit is set.
  always_ff @(posedge clock) begin
    if (commit) begin
      case (cmd_q)
        CMD_ENQ: begin
          slot_data[free_idx] <= data_q;
          slot_prev[free_idx] <= tail;
          if (count != '0) slot_next[tail] <= free_idx;
        end
        CMD_WRITE: slot_data[idx_q] <= data_q;
        CMD_BUMP: begin
          if (idx_q != tail) begin
            // Unlink from the current position; tail is after idx_q, so
            // its successor always exists.
            if (idx_q != head) slot_next[sel_prev] <= sel_next;
            slot_prev[sel_next] <= sel_prev;
            // Relink behind the old tail.
            slot_next[tail]  <= idx_q;
            slot_prev[idx_q] <= tail;
          end
        end
        CMD_DELETE: begin
          if (idx_q != head) slot_next[sel_prev] <= sel_next;
          if (idx_q != tail) slot_prev[sel_next] <= sel_prev;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/index_queue.md
INDEX_QUEUE -- requirements
Module: index_queue

Interface
REQ-001 The block SHALL have parameter IDX_WIDTH, default 2, slot index width; depth D = 2^IDX_WIDTH.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, payload width per slot.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset:
- clock  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have the following remaining ports:
- command  input  4  operation code, sampled with enable.
- enable  input  1  request strobe; accepted only when ready=1.
- idx_in  input  IDX_WIDTH  target slot for index-addressed commands.
- data_in  input  DATA_WIDTH  payload for ENQUEUE/WRITE.
- ready  output  1  idle, outputs valid, request may be issued.
- crashed  output  1  sticky protocol-error flag.
- idx_out  output  IDX_WIDTH  slot result.
- data_out  output  DATA_WIDTH  payload result.
- empty  output  1  no occupied slots.
- full  output  1  all D slots occupied.

Function
REQ-005 The block SHALL hold D slots (data, valid, next, prev) as a doubly linked queue with head, tail and an IDX_WIDTH+1-bit count.
REQ-006 Commands SHALL be: 1 ENQUEUE, 2 DEQUEUE, 3 READ, 4 WRITE, 5 BUMP, 6 DELETE; 0 SHALL be NOP; 7-15 SHALL be illegal.
REQ-007 The FSM SHALL have states IDLE, EXEC and CRASH; ready=1 only in IDLE.
REQ-008 Transitions:
- IDLE with enable=1 -> EXEC, capturing command/idx_in/data_in.
- EXEC -> IDLE, or -> CRASH on error.
- CRASH holds until reset.
REQ-009 Latency SHALL be exactly 2 cycles from the accepting edge to ready=1, and results SHALL be valid while ready=1.
REQ-010 enable while ready=0 SHALL be ignored with no state change.
REQ-011 ENQUEUE SHALL allocate the lowest-numbered free slot, store data_in, link it at the tail, count+1, and return idx_out=slot.
REQ-012 DEQUEUE SHALL unlink the head, free it, count-1, and return idx_out=old head and data_out=its data.
REQ-013 READ SHALL return data_out=data[idx_in] and idx_out=idx_in with no state change.
REQ-014 WRITE SHALL set data[idx_in]=data_in without changing order.
REQ-015 BUMP SHALL move slot idx_in to the tail; it SHALL be a no-op if idx_in is already the tail.
REQ-016 DELETE SHALL unlink and free slot idx_in from any position (head, middle or tail), count-1.
REQ-017 NOP SHALL complete normally with outputs unchanged.
REQ-018 The following SHALL be errors:
- ENQUEUE when full.
- DEQUEUE when empty.
- READ/WRITE/BUMP/DELETE on a free slot.
- Any illegal code.
REQ-019 On error, queue state SHALL be unchanged, crashed SHALL be set to 1, and ready SHALL stay 0 until reset.
REQ-020 Outputs SHALL be:
- empty = (count==0) and full = (count==D), both registered and updated with the EXEC edge.
- idx_out/data_out held between operations.
REQ-021 A single-element queue SHALL have head==tail, and removing it SHALL return the block to empty.

Reset
REQ-022 On reset assertion the block SHALL asynchronously drive:
- ready=1, crashed=0, idx_out=0, data_out=0, empty=1, full=0.
- count=0, all slots free, FSM=IDLE.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no partial update visible after release.
REQ-024 The first request SHALL be accepted on the first clock edge after reset deasserts.

Verification
REQ-025 Fill test: ENQUEUE 0xA0, 0xA1, 0xA2, 0xA3 -> idx_out 0,1,2,3; after the fourth, full=1 and ready rises 2 cycles after each enable.
REQ-026 Order test: with REQ-025 state, DEQUEUE twice -> (idx 0, 0xA0), (idx 1, 0xA1), count=2; then ENQUEUE 0xB0 -> idx_out=0.
REQ-027 BUMP/DELETE test: from queue 0,1,2,3, BUMP 1 then DELETE 2 -> subsequent DEQUEUEs yield idx 0, 3, 1, and empty=1 after the last.
REQ-028 Read/write test: WRITE idx 2 = 0x5C on an occupied slot, then READ 2 -> data_out=0x5C, with order unchanged.
REQ-029 Error test: DEQUEUE on empty after reset -> crashed=1 and ready=0, and subsequent enables are ignored; reset -> crashed=0 and ready=1.
REQ-030 Reset test: assert reset in EXEC of an ENQUEUE -> immediately empty=1 and ready=1, and after release READ 0 raises crashed.
